pid_scheduler: RTL

Time-multiplexes one shared `pid` datapath core across `NCH` motor channels. On each control-loop `tick` it issues every channel's setpoints, measurements, gains and stored loop state into the core on consecutive cycles. It tracks each issue through a tag pipeline matched to the core latency and writes results back into per-channel state and output registers. It sits between the motor register file / encoder front end and the PWM generators.

---
 rtl/pid_scheduler.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pid_scheduler.sv
// pid_scheduler: time-multiplexes one shared PID core across NCH motor channels
module pid_scheduler #(
   parameter int NCH     = 4,
   parameter int PID_LAT = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick,
   input  logic [NCH-1:0]     ch_en,
   input  logic [NCH-1:0]     int_clr,
   input  logic [13*NCH-1:0]  pos_d_all,
   input  logic [13*NCH-1:0]  pos_all,
   input  logic [13*NCH-1:0]  vel_d_all,
   input  logic [13*NCH-1:0]  vel_all,
   input  logic [13*NCH-1:0]  kp_n_all,
   input  logic [13*NCH-1:0]  ki_n_all,
   input  logic [13*NCH-1:0]  kd_n_all,
   input  logic [8*NCH-1:0]   kp_d_all,
   input  logic [8*NCH-1:0]   ki_d_all,
   input  logic [8*NCH-1:0]   kd_d_all,
   output logic [12:0]        pid_pos_d,
   output logic [12:0]        pid_pos,
   output logic [12:0]        pid_vel_d,
   output logic [12:0]        pid_vel,
   output logic [12:0]        pid_err_prev,
   output logic [12:0]        pid_int_err_prev,
   output logic [12:0]        pid_kp_n,
   output logic [12:0]        pid_ki_n,
   output logic [12:0]        pid_kd_n,
   output logic [7:0]         pid_kp_d,
   output logic [7:0]         pid_ki_d,
   output logic [7:0]         pid_kd_d,
   input  logic [12:0]        pid_pwm,
   input  logic [12:0]        pid_err,
   input  logic [12:0]        pid_int_err,
   input  logic               pid_dir,
   output logic [13*NCH-1:0]  pwm_all,
   output logic [NCH-1:0]     dir,
   output logic               busy,
   output logic               done,
   output logic               overrun
);
   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IW-1:0] LAST = IW'(NCH - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
   typedef struct packed {
      logic          v;
      logic [IW-1:0] tag;
      logic          en;
   } tag_t;

   state_t         state_q, state_d;
   logic [IW-1:0]  idx_q, idx_d;
   tag_t           pipe_q [PID_LAT];
   tag_t           pipe_d [PID_LAT];
   logic [12:0]    err_q [NCH];
   logic [12:0]    err_d [NCH];
   logic [12:0]    int_q [NCH];
   logic [12:0]    int_d [NCH];
   logic [12:0]    pwm_q [NCH];
   logic [12:0]    pwm_d [NCH];
   logic [NCH-1:0] dir_q, dir_d;
   logic           busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;
   logic           issue;
   tag_t           head;

   assign issue   = (state_q == ISSUE);
   assign head    = pipe_q[PID_LAT-1];
   assign dir     = dir_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign overrun = ovr_q;

   for (genvar i = 0; i < NCH; i++) begin : g_pwm
      assign pwm_all[13*i +: 13] = pwm_q[i];
   end

   // channel idx operands onto the core while issuing, zero otherwise
   always_comb begin
      pid_pos_d        = issue ? pos_d_all[13*idx_q +: 13] : '0;
      pid_pos          = issue ? pos_all[13*idx_q +: 13]   : '0;
      pid_vel_d        = issue ? vel_d_all[13*idx_q +: 13] : '0;
      pid_vel          = issue ? vel_all[13*idx_q +: 13]   : '0;
      pid_kp_n         = issue ? kp_n_all[13*idx_q +: 13]  : '0;
      pid_ki_n         = issue ? ki_n_all[13*idx_q +: 13]  : '0;
      pid_kd_n         = issue ? kd_n_all[13*idx_q +: 13]  : '0;
      pid_kp_d         = issue ? kp_d_all[8*idx_q +: 8]    : '0;
      pid_ki_d         = issue ? ki_d_all[8*idx_q +: 8]    : '0;
      pid_kd_d         = issue ? kd_d_all[8*idx_q +: 8]    : '0;
      pid_err_prev     = issue ? err_q[idx_q] : '0;
      pid_int_err_prev = (issue && ch_en[idx_q] && !int_clr[idx_q]) ? int_q[idx_q] : '0;
   end

   // next state: frame sequencing, tag pipe shift and result writeback
   always_comb begin
      state_d = (state_q == IDLE)  ? (tick ? ISSUE : IDLE) :
                (state_q == ISSUE) ? ((idx_q == LAST) ? DRAIN : ISSUE) :
                (state_q == DRAIN) ? ((head.v && head.tag == LAST) ? DONE : DRAIN) :
                IDLE;
      idx_d          = (issue && idx_q != LAST) ? idx_q + IW'(1) : '0;
      busy_d         = (state_d == ISSUE) || (state_d == DRAIN);
      done_d         = (state_d == DONE);
      ovr_d          = tick && (state_q != IDLE);
      pipe_d[0].v    = issue;
      pipe_d[0].tag  = issue ? idx_q : '0;
      pipe_d[0].en   = issue && ch_en[idx_q];
      for (int k = 1; k < PID_LAT; k++) pipe_d[k] = pipe_q[k-1];
      err_d = err_q;
      int_d = int_q;
      pwm_d = pwm_q;
      dir_d = dir_q;
      if (head.v) begin
         err_d[head.tag] = head.en ? pid_err     : '0;
         int_d[head.tag] = head.en ? pid_int_err : '0;
         pwm_d[head.tag] = head.en ? pid_pwm     : '0;
         dir_d[head.tag] = head.en && pid_dir;
      end
   end

   // single register stage for FSM, tag pipe, loop state and outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         pipe_q  <= '{default: '0};
         err_q   <= '{default: '0};
         int_q   <= '{default: '0};
         pwm_q   <= '{default: '0};
         dir_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pipe_q  <= pipe_d;
         err_q   <= err_d;
         int_q   <= int_d;
         pwm_q   <= pwm_d;
         dir_q   <= dir_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
      end
   end
endmodule
